// File: rtl/instr_packer.sv
// -----------------------------------------------------------------------------
// instr_packer
//   Packs opcode/m/rd/rs1/imm fields into 16-bit instruction words and writes
//   them one after another into instruction memory. The program loader uses it
//   to fill instruction memory before the core runs.
//   Input side is a valid/ready handshake. Each accepted word produces exactly
//   one registered memory write on the following clock.
//
//   Optional feature macro: PACK_CHECK_EN
//     Defined   : an opcode above MAX_OPC is still accepted but is not written.
//                 In that case the sticky err flag is set.
//     Undefined : every opcode is written, and err is held at 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   begin a load session (honoured in IDLE only)
//   finish     in   end the session (honoured in LOAD/FULL)
//   in_valid   in   field set valid
//   in_ready   out  packer can accept fields (high in LOAD only)
//   opcode     in   [3:0] -> word[15:12]
//   m          in         -> word[11]
//   rd         in   [2:0] -> word[10:8]
//   rs1        in   [2:0] -> word[7:5]
//   imm        in   [4:0] -> word[4:0]
//   mem_we     out  one-cycle write strobe
//   mem_addr   out  [ADDR_W-1:0] write address
//   mem_wdata  out  [15:0] packed instruction word
//   count      out  [ADDR_W:0] words written this session
//   full       out  DEPTH words written (FULL state)
//   done       out  one-cycle pulse on return to IDLE
//   err        out  sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module instr_packer #(
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              DEPTH     = 256,
  parameter logic [3:0]      MAX_OPC   = 4'hB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic              m,
  input  logic [2:0]        rd,
  input  logic [2:0]        rs1,
  input  logic [4:0]        imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic            xfer;
  logic            opc_illegal;
  logic            legal;
  logic [ADDR_W:0] count_inc;
  logic [15:0]     word;

  // Ready is a pure function of state, so it drops on the cycle after the
  // transfer that fills the session.
  assign in_ready    = (state == LOAD);
  assign xfer        = in_valid & in_ready;
  assign count_inc   = count + ONE_C;
  assign word        = {opcode, m, rd, rs1, imm};
  assign opc_illegal = (opcode > MAX_OPC);

`ifdef PACK_CHECK_EN
  assign legal = ~opc_illegal;
`else
  logic unused_opc_chk;
  assign legal          = 1'b1;
  assign unused_opc_chk = opc_illegal;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // A transfer sampled in the same cycle as reset is dropped.
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 16'h0000;
      count     <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          // When start and finish arrive together, start wins.
          if (start) begin
            state <= LOAD;
            count <= '0;
            err   <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (legal) begin
              mem_we    <= 1'b1;
              mem_wdata <= word;
              // The address wraps modulo 2^ADDR_W without any flag.
              mem_addr  <= BASE_ADDR + count[ADDR_W-1:0];
              count     <= count_inc;
              if (count_inc == DEPTH_C && !finish) begin
                state <= FULL;
                full  <= 1'b1;
              end
            end else begin
`ifdef PACK_CHECK_EN
              err <= 1'b1;
`endif
            end
          end
          // When a transfer and finish arrive together, the word above is
          // still written before returning to IDLE.
          if (finish) begin
            state <= IDLE;
            done  <= 1'b1;
            full  <= 1'b0;
          end
        end
        FULL: begin
          if (finish) begin
            state <= IDLE;
            done  <= 1'b1;
            full  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
